stbus_rx_deframer: RTL and testbench
====================================

// Module: stbus_rx_deframer
// PURPOSE
//  Receive side of the DT TDM link. Oversamples f0, c4 and data_from_dt in the clk50 domain and
//  finds the ST-bus frame. Deserialises each timeslot MSB-first and pushes enabled channel bytes
//  with their channel number into a FIFO. Raises cpu_int so the CPU/STM side can drain it.
//  Sits directly upstream of the DT->STM converter path.
// PARAMETERS
//  CHANNELS     32            timeslots per frame (256 bits / 125 us)
//  CH_BITS      8             bits per timeslot
//  FIFO_DEPTH   16            entries, power of two
//  CH_MASK      32'hFFFFFFFF  bit n=1 -> channel n is captured
//  INT_LEVEL    8             FIFO occupancy that asserts cpu_int
// PORTS
//  clk50         in   1   system clock, 50 MHz; all logic on posedge
//  reset_n       in   1   synchronous, active-low reset
//  f0            in   1   frame pulse, active low, async to clk50
//  c4            in   1   4.096 MHz bit clock (2x bit rate), async to clk50
//  data_from_dt  in   1   serial TDM data, async to clk50
//  enable        in   1   1 = receiver runs; 0 = IDLE
//  rd_en         in   1   pop FIFO head (ignored when fifo_empty)
//  int_ack       in   1   clears frame_done and sticky flags
//  rd_data       out  8   FIFO head byte (valid when !fifo_empty)
//  rd_ch         out  5   channel number of rd_data
//  fifo_empty    out  1   FIFO holds no entries
//  fifo_count    out  5   occupancy, 0..FIFO_DEPTH
//  overflow      out  1   sticky: byte dropped on full FIFO
//  frame_err     out  1   sticky: frame pulse misplaced or missing
//  cpu_int       out  1   level: fifo_count>=INT_LEVEL | frame_done | overflow | frame_err
// BEHAVIOUR
//  - Reset: all outputs 0 except fifo_empty=1. FIFO pointers 0. State IDLE.
//  - Input sync: two-flop synchroniser on f0, c4 and data_from_dt.
//  - c4_rise = one-cycle pulse on a synced 0->1 transition of c4.
//  - FS (frame start) = c4_rise while synced f0==0.
//  - State IDLE: enable=0. Forced from any state when enable falls. FIFO keeps its content.
//  - State HUNT: wait for FS. On FS: go to RUN, bit_cnt=0, phase=0.
//  - State RUN, each c4_rise:
//      - Toggle phase.
//      - On phase 0->1: sample data into the shift register (MSB first), then bit_cnt++.
//  - A byte completes when bit_cnt[2:0] wraps to 0. If CH_MASK[ch] is set, push {ch, byte} the
//    same cycle.
//  - bit_cnt is 8 bits; ch = bit_cnt[7:3] of the completed byte.
//  - Frame done: channel 31 completes. Set frame_done (held until int_ack).
//  - FS in RUN with bit_cnt!=0: set frame_err. Discard the partial byte and realign: bit_cnt=0,
//    phase=0. Stay in RUN.
//  - 256 further bits with no FS after channel 31: set frame_err and go to HUNT.
//  - FIFO:
//      - Push and pop in the same cycle: both occur and count is unchanged. When full, this
//        succeeds (pop frees the slot).
//      - Push on full without pop: byte dropped, overflow=1.
//      - Pop on empty: ignored, no error.
//      - rd_data/rd_ch are combinational from the head entry. Latency push->visible = 1 cycle.
//  - int_ack clears frame_done, overflow and frame_err. A set event in the same cycle wins over
//    the clear.
//  - cpu_int is registered: 1 cycle after its cause.
//  - reset_n low mid-frame: immediate return to reset values. FIFO content lost.
// STRUCTURE
//  - Shared package: ST_CHANNELS, ST_CH_BITS, ST_BITS_PER_FRAME=256; state enum {IDLE,HUNT,RUN};
//    FIFO entry type {ch[4:0], data[7:0]}.
//  - One sub-module: stbus_rx_fifo (sync FIFO, width 13, depth FIFO_DEPTH, count/empty/full).
//  - Synchroniser, edge detect, FSM and shifter stay in this module.
// TESTING
//  1. Frame of ch n = 8'hA0+n, full mask, FIFO drained as filled.
//     -> 32 pops in order, rd_ch 0..31, data A0..BF.
//     -> cpu_int from frame_done after ch31.
//  2. CH_MASK=32'h0000_0005, ch0=8'h3C, ch2=8'hC3.
//     -> exactly 2 entries: {0,3C} then {2,C3}. fifo_count=2.
//  3. No reads, 17 enabled bytes.
//     -> fifo_count=16, overflow=1 on 17th, cpu_int=1.
//     -> int_ack clears overflow. Entries 0..15 intact.
//  4. FS injected at bit 100 of a frame.
//     -> frame_err=1, partial byte not pushed.
//     -> next 8 bits land as ch0.
//  5. f0 held high after one good frame.
//     -> after 256 more bits: frame_err=1, state HUNT, no further pushes until FS.
//  6. reset_n low for 1 cycle mid-frame (FIFO holds 5 entries).
//     -> fifo_empty=1, count=0, all flags 0, state IDLE (enable=0) or HUNT.

Source files
------------

// File: rtl/stbus_rx_deframer_pkg.sv
// Shared constants and types for the ST-bus receive deframer.
package stbus_rx_deframer_pkg;

    localparam int ST_CHANNELS       = 32;
    localparam int ST_CH_BITS        = 8;
    localparam int ST_BITS_PER_FRAME = 256;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HUNT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    typedef struct packed {
        logic [4:0] ch;
        logic [7:0] data;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/stbus_rx_deframer_fifo.sv
// Single-clock FIFO for received timeslot entries; a push and a pop in the same cycle
// both take effect, even when the FIFO is full.
module stbus_rx_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/stbus_rx_deframer.sv
// ST-bus receive deframer: locks to the frame pulse, deserialises timeslots MSB-first
// and queues enabled channel bytes for the CPU side.
//  state | meaning
//  IDLE  | receiver disabled, FIFO contents kept
//  HUNT  | waiting for a frame pulse to align
//  RUN   | aligned, deserialising timeslots
module stbus_rx_deframer
    import stbus_rx_deframer_pkg::*;
#(
    parameter int          CHANNELS   = ST_CHANNELS,
    parameter int          CH_BITS    = ST_CH_BITS,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] CH_MASK    = 32'hFFFF_FFFF,
    parameter int          INT_LEVEL  = 8
) (
    input  logic       clk50,
    input  logic       reset_n,
    input  logic       f0,
    input  logic       c4,
    input  logic       data_from_dt,
    input  logic       enable,
    input  logic       rd_en,
    input  logic       int_ack,
    output logic [7:0] rd_data,
    output logic [4:0] rd_ch,
    output logic       fifo_empty,
    output logic [4:0] fifo_count,
    output logic       overflow,
    output logic       frame_err,
    output logic       cpu_int
);
    localparam int               CNT_W    = $clog2(ST_BITS_PER_FRAME);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHANNELS * CH_BITS - 1);
    localparam logic [2:0]       BYTE_END = 3'(CH_BITS - 1);

    logic [1:0]       f0_sync;
    logic [1:0]       c4_sync;
    logic [1:0]       data_sync;
    logic             c4_prev;
    logic             c4_rise;
    logic             fs;

    logic [1:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic             phase;
    logic             past_end;
    logic [6:0]       shift;
    logic             frame_done;

    logic             run;
    logic             sample;
    logic             byte_done;
    logic             frame_end;
    logic             timeout;
    logic             fs_err;
    logic             push;
    logic             ovf_evt;
    logic             fifo_full;
    logic [7:0]       byte_val;
    logic [4:0]       byte_ch;
    fifo_entry_t      wr_entry;
    fifo_entry_t      head;
    logic [ENTRY_W-1:0] head_bits;

    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            f0_sync   <= 2'b11;
            c4_sync   <= 2'b00;
            data_sync <= 2'b00;
            c4_prev   <= 1'b0;
        end else begin
            f0_sync   <= {f0_sync[0], f0};
            c4_sync   <= {c4_sync[0], c4};
            data_sync <= {data_sync[0], data_from_dt};
            c4_prev   <= c4_sync[1];
        end
    end

    assign c4_rise   = c4_sync[1] && !c4_prev;
    assign fs        = c4_rise && !f0_sync[1];

    assign run       = enable && (state == ST_RUN);
    assign sample    = run && c4_rise && !fs && !phase;
    assign byte_done = sample && (bit_cnt[2:0] == BYTE_END);
    assign byte_val  = {shift, data_sync[1]};
    assign byte_ch   = bit_cnt[CNT_W-1:3];
    assign frame_end = byte_done && (bit_cnt == LAST_BIT);
    // a second frame end with no frame pulse in between means sync was lost
    assign timeout   = frame_end && past_end;
    assign fs_err    = run && fs && (bit_cnt != '0);
    assign push      = byte_done && CH_MASK[byte_ch];
    assign ovf_evt   = push && fifo_full && !rd_en;
    assign wr_entry  = '{ch: byte_ch, data: byte_val};

    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            phase    <= 1'b0;
            past_end <= 1'b0;
            shift    <= '0;
        end else if (!enable) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state <= ST_HUNT;
                ST_HUNT: begin
                    if (fs) begin
                        state    <= ST_RUN;
                        bit_cnt  <= '0;
                        phase    <= 1'b0;
                        past_end <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (fs) begin
                        bit_cnt  <= '0;
                        phase    <= 1'b0;
                        past_end <= 1'b0;
                    end else if (c4_rise) begin
                        phase <= !phase;
                        if (!phase) begin
                            shift   <= byte_val[6:0];
                            bit_cnt <= bit_cnt + 1'b1;
                            if (frame_end) begin
                                past_end <= 1'b1;
                                if (past_end) state <= ST_HUNT;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
            cpu_int    <= 1'b0;
        end else begin
            if (frame_end)            frame_done <= 1'b1;
            else if (int_ack)         frame_done <= 1'b0;
            if (ovf_evt)              overflow   <= 1'b1;
            else if (int_ack)         overflow   <= 1'b0;
            if (fs_err || timeout)    frame_err  <= 1'b1;
            else if (int_ack)         frame_err  <= 1'b0;
            cpu_int <= (fifo_count >= 5'(INT_LEVEL)) || frame_done || overflow || frame_err;
        end
    end

    stbus_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk50),
        .reset_n (reset_n),
        .push    (push),
        .pop     (rd_en),
        .wr_data (wr_entry),
        .rd_data (head_bits),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign head    = fifo_entry_t'(head_bits);
    assign rd_data = fifo_empty ? 8'h00 : head.data;
    assign rd_ch   = fifo_empty ? 5'd0  : head.ch;

endmodule

// File: tb/tb_stbus_rx_deframer.sv
// Directed/random bench: two deframers (full mask and mask 0x5) fed from one serial stream,
// checked against a byte-level queue model of each FIFO and its flags.
module tb_stbus_rx_deframer;

    localparam int          H      = 4;
    localparam int          DEPTH  = 16;
    localparam logic [31:0] B_MASK = 32'h0000_0005;

    logic       clk50;
    logic       reset_n;
    logic       f0;
    logic       c4;
    logic       data_from_dt;
    logic       enable;
    logic       rd_en_a;
    logic       rd_en_b;
    logic       int_ack;
    logic [7:0] rd_data_a, rd_data_b;
    logic [4:0] rd_ch_a, rd_ch_b;
    logic       fifo_empty_a, fifo_empty_b;
    logic [4:0] fifo_count_a, fifo_count_b;
    logic       overflow_a, overflow_b;
    logic       frame_err_a, frame_err_b;
    logic       cpu_int_a, cpu_int_b;

    int          checks;
    int          failures;
    logic [12:0] qa[$];
    logic [12:0] qb[$];
    bit          ovf_a, ovf_b, fd, ferr, drain_a;
    logic [7:0]  frame[32];

    stbus_rx_deframer dut_a (
        .clk50(clk50), .reset_n(reset_n), .f0(f0), .c4(c4), .data_from_dt(data_from_dt),
        .enable(enable), .rd_en(rd_en_a), .int_ack(int_ack), .rd_data(rd_data_a),
        .rd_ch(rd_ch_a), .fifo_empty(fifo_empty_a), .fifo_count(fifo_count_a),
        .overflow(overflow_a), .frame_err(frame_err_a), .cpu_int(cpu_int_a)
    );

    stbus_rx_deframer #(.CH_MASK(B_MASK)) dut_b (
        .clk50(clk50), .reset_n(reset_n), .f0(f0), .c4(c4), .data_from_dt(data_from_dt),
        .enable(enable), .rd_en(rd_en_b), .int_ack(int_ack), .rd_data(rd_data_b),
        .rd_ch(rd_ch_b), .fifo_empty(fifo_empty_b), .fifo_count(fifo_count_b),
        .overflow(overflow_b), .frame_err(frame_err_b), .cpu_int(cpu_int_b)
    );

    initial clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input bit b, input string tag);
        int          n;
        bit          ovf;
        logic [12:0] h;
        repeat (2) @(negedge clk50);
        n   = b ? qb.size() : qa.size();
        ovf = b ? ovf_b : ovf_a;
        check({tag, "_count"}, b ? 32'(fifo_count_b) : 32'(fifo_count_a), 32'(n));
        check({tag, "_empty"}, b ? 32'(fifo_empty_b) : 32'(fifo_empty_a), 32'(n == 0));
        check({tag, "_ovf"},   b ? 32'(overflow_b)   : 32'(overflow_a),   32'(ovf));
        check({tag, "_ferr"},  b ? 32'(frame_err_b)  : 32'(frame_err_a),  32'(ferr));
        check({tag, "_int"},   b ? 32'(cpu_int_b)    : 32'(cpu_int_a),
              32'((n >= 8) || fd || ovf || ferr));
        if (n > 0) begin
            h = b ? qb[0] : qa[0];
            check({tag, "_head_ch"},   b ? 32'(rd_ch_b)   : 32'(rd_ch_a),   32'(h[12:8]));
            check({tag, "_head_data"}, b ? 32'(rd_data_b) : 32'(rd_data_a), 32'(h[7:0]));
        end
    endtask

    task automatic pop_one(input bit b);
        logic [12:0] e;
        string       p;
        p = b ? "b" : "a";
        if (b) e = qb.pop_front(); else e = qa.pop_front();
        check({p, "_pop_ch"},   b ? 32'(rd_ch_b)   : 32'(rd_ch_a),   32'(e[12:8]));
        check({p, "_pop_data"}, b ? 32'(rd_data_b) : 32'(rd_data_a), 32'(e[7:0]));
        if (b) rd_en_b = 1'b1; else rd_en_a = 1'b1;
        @(negedge clk50);
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
        @(negedge clk50);
    endtask

    task automatic drain(input bit b, input string tag);
        while ((b ? qb.size() : qa.size()) > 0) pop_one(b);
        check_flags(b, tag);
    endtask

    task automatic ack();
        int_ack = 1'b1;
        @(negedge clk50);
        int_ack = 1'b0;
        fd = 0; ferr = 0; ovf_a = 0; ovf_b = 0;
        repeat (3) @(negedge clk50);
    endtask

    // one full c4 period; f0 and data settle during the low half, the rise is the event
    task automatic c4_cycle(input logic fv, input logic dv);
        f0 = fv;
        data_from_dt = dv;
        c4 = 1'b0;
        repeat (H) @(negedge clk50);
        c4 = 1'b1;
        repeat (H) @(negedge clk50);
    endtask

    task automatic send_fs();
        c4_cycle(1'b0, 1'b0);
    endtask

    task automatic send_bit(input logic b);
        c4_cycle(1'b1, b);
        c4_cycle(1'b1, b);
    endtask

    task automatic send_byte(input int ch, input logic [7:0] val, input bit live, input bit lost);
        logic [31:0] bm;
        logic [12:0] e;
        bm = B_MASK;
        for (int i = 7; i >= 0; i--) send_bit(val[i]);
        if (live) begin
            e = {5'(ch), val};
            if (qa.size() < DEPTH) qa.push_back(e); else ovf_a = 1'b1;
            if (bm[ch]) begin
                if (qb.size() < DEPTH) qb.push_back(e); else ovf_b = 1'b1;
            end
            if (ch == 31) fd = 1'b1;
            if (lost) ferr = 1'b1;
        end
        check_flags(1'b0, "a_byte");
        check_flags(1'b1, "b_byte");
        if (drain_a) while (qa.size() > 0) pop_one(1'b0);
    endtask

    task automatic send_frame();
        for (int ch = 0; ch < 32; ch++) send_byte(ch, frame[ch], 1'b1, 1'b0);
    endtask

    task automatic rand_frame();
        for (int ch = 0; ch < 32; ch++) frame[ch] = 8'($urandom);
    endtask

    initial begin
        checks = 0; failures = 0;
        ovf_a = 0; ovf_b = 0; fd = 0; ferr = 0; drain_a = 0;
        reset_n = 1'b0; enable = 1'b0; f0 = 1'b1; c4 = 1'b1; data_from_dt = 1'b0;
        rd_en_a = 1'b0; rd_en_b = 1'b0; int_ack = 1'b0;
        repeat (4) @(negedge clk50);
        check_flags(1'b0, "rst_a");
        check_flags(1'b1, "rst_b");
        check("rst_rd_data", 32'(rd_data_a), 32'h0);
        check("rst_rd_ch", 32'(rd_ch_a), 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk50);
        enable = 1'b1;
        repeat (4) @(negedge clk50);

        // frame of A0+n, A drained as filled
        drain_a = 1;
        for (int ch = 0; ch < 32; ch++) frame[ch] = 8'hA0 + 8'(ch);
        send_fs();
        send_frame();
        check_flags(1'b0, "t1_end");
        ack();
        check_flags(1'b0, "t1_ack");
        drain(1'b1, "t1_b");

        // ch0=3C, ch2=C3 into the mask-0x5 receiver
        rand_frame();
        frame[0] = 8'h3C;
        frame[2] = 8'hC3;
        send_fs();
        send_frame();
        check_flags(1'b1, "t2_b");
        drain(1'b1, "t2_b_drain");
        ack();

        // no reads: 16 stored, 17th overflows
        drain_a = 0;
        rand_frame();
        send_fs();
        send_frame();
        ack();
        check_flags(1'b0, "t3_ack");
        drain(1'b0, "t3_drain");
        drain(1'b1, "t3_b");

        // frame pulse at bit 100, then a realigned frame
        drain_a = 1;
        rand_frame();
        send_fs();
        for (int ch = 0; ch < 12; ch++) send_byte(ch, frame[ch], 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        send_fs();
        ferr = 1'b1;
        check_flags(1'b0, "t4_err");
        check_flags(1'b1, "t4_err_b");
        rand_frame();
        send_frame();
        ack();
        drain(1'b1, "t4_b");

        // f0 stays high: 256 bits later sync is lost, then nothing until a frame pulse
        rand_frame();
        for (int ch = 0; ch < 32; ch++) send_byte(ch, frame[ch], 1'b1, ch == 31);
        for (int ch = 0; ch < 4; ch++) send_byte(ch, 8'($urandom), 1'b0, 1'b0);
        drain(1'b1, "t5_b");
        drain_a = 0;
        send_fs();
        for (int ch = 0; ch < 5; ch++) send_byte(ch, 8'($urandom), 1'b1, 1'b0);

        // one-cycle reset with five entries held
        reset_n = 1'b0;
        @(negedge clk50);
        reset_n = 1'b1;
        qa.delete(); qb.delete();
        ovf_a = 0; ovf_b = 0; fd = 0; ferr = 0;
        repeat (3) @(negedge clk50);
        check_flags(1'b0, "t6_rst");
        check_flags(1'b1, "t6_rst_b");
        send_byte(0, 8'($urandom), 1'b0, 1'b0);
        send_byte(1, 8'($urandom), 1'b0, 1'b0);
        send_fs();
        send_byte(0, 8'($urandom), 1'b1, 1'b0);

        // disabled receiver ignores the line and keeps its FIFO
        enable = 1'b0;
        repeat (2) @(negedge clk50);
        send_fs();
        send_byte(0, 8'($urandom), 1'b0, 1'b0);
        enable = 1'b1;
        repeat (4) @(negedge clk50);
        send_byte(1, 8'($urandom), 1'b0, 1'b0);
        drain(1'b0, "t7_a");
        drain(1'b1, "t7_b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
